bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-packed-BCD converter (shift-add-3 / double-dabble).
//   Sits directly upstream of bcd_adder and produces its packed-BCD A/B operands
//   from binary counts.
//   One bit per clock; valid/ready handshakes on both sides.
//   Results >= 10**DIGITS are flagged and reported modulo 10**DIGITS.
// PARAMETERS
//   BIN_W   8  binary input width (>=1)
//   DIGITS  2  BCD digits out; bcd_out width = 4*DIGITS (>=1)
// PORTS
//   clk        in   1         single clock, rising edge
//   rst        in   1         asynchronous, active-high reset
//   in_valid   in   1         bin_in valid
//   in_ready   out  1         converter idle, accepts bin_in
//   bin_in     in   BIN_W     unsigned binary operand
//   out_valid  out  1         bcd_out/ovf valid
//   out_ready  in   1         consumer accepts result
//   bcd_out    out  4*DIGITS  packed BCD, digit0 in [3:0]
//   ovf        out  1         bin_in >= 10**DIGITS
// BEHAVIOUR
//   Reset (async, active-high): state=IDLE, out_valid=0, bcd_out=0, ovf=0,
//     counter=0. in_ready=0 while rst=1, 1 once released (IDLE).
//   FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready edge: capture bin_in into shift reg,
//     clear BCD accum, set ovf=(bin_in >= 10**DIGITS), counter=BIN_W, go SHIFT.
//   SHIFT: in_ready=0. Each edge: every accum digit >=5 gets +3, then
//     {accum,bin} shifts left 1 (bin MSB into digit0 LSB; accum top bit
//     discarded, giving result mod 10**DIGITS), counter-1. Edge with counter==1
//     goes DONE.
//   DONE: out_valid=1, bcd_out/ovf driven from regs, stable until accepted.
//     On out_valid&&out_ready edge: out_valid=0, go IDLE. in_valid ignored.
//   Latency: capture on edge T -> out_valid high from edge T+BIN_W.
//     Best-case throughput one result per BIN_W+2 cycles. No capture in the
//     same cycle as output acceptance.
//   bcd_out holds last result after acceptance, until next capture clears it.
//   Boundaries:
//     - bin_in=0 -> bcd_out all zeros.
//     - bin_in = 10**DIGITS-1 -> all 9s, ovf=0.
//     - bin_in=10**DIGITS -> zeros, ovf=1.
//     - out_ready held high while in DONE -> accepted on the first DONE edge.
//     - rst mid-SHIFT/DONE -> result discarded, out_valid drops immediately.
//     - ovf is computed with enough width for BIN_W (no truncation).
//   Every accum digit is 0..9 at every SHIFT boundary (assertion).
// STRUCTURE
//   bcd_pkg:
//     - typedef logic [3:0] bcd_digit_t
//     - enum cvt_state_e {IDLE,SHIFT,DONE}
//     - function add3_fix(bcd_digit_t)
//   One sub-module: bcd_add3_cell (comb. digit >=5 ? +3 : pass), generated
//     DIGITS times.
//   Counter width $clog2(BIN_W+1). All state in one always_ff.
// TESTING (BIN_W=8, DIGITS=2)
//   1 rst pulse mid-idle -> out_valid=0, bcd_out=8'h00, ovf=0;
//     in_ready 0 during rst, 1 after.
//   2 bin_in=9, out_ready=1 -> bcd_out=8'h09, ovf=0; out_valid 8 cycles
//     after capture edge.
//   3 sweep 0,10,41,99 -> 8'h00,8'h10,8'h41,8'h99.
//     Feed 41 and 11 into bcd_adder (Cin=0) -> S=8'h52, Cout=0.
//   4 bin_in=100 -> 8'h00, ovf=1; bin_in=255 -> bcd_out=8'h55, ovf=1.
//   5 Backpressure: out_ready=0 for 5 cycles in DONE -> bcd_out stable,
//     in_ready=0, in_valid pulses ignored; release -> one handshake, IDLE next.
//   6 rst asserted 4 cycles into SHIFT of 77 -> out_valid never rises;
//     after release convert 42 -> 8'h42.
//   Also: random 0..255 vs ref model {bin%100 as BCD, bin>=100}.
//     Assert no digit >9 and no in_ready&&out_valid overlap.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   bcd_digit_t : one packed BCD digit
//   cvt_state_e : converter FSM states
//   add3_fix    : double-dabble digit correction (>=5 gets +3)
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cvt_state_e;

  function automatic bcd_digit_t add3_fix(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Combinational double-dabble correction for a single BCD digit.
//   digit_in    : accumulator digit before the shift
//   digit_out_c : digit corrected so the following left shift stays decimal
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out_c
);

  assign digit_out_c = add3_fix(digit_in);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one input bit per clock.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake, bin_in captured when both high
//   out_valid/out_ready  : result handshake, bcd_out/ovf held until accepted
//   bcd_out              : packed BCD result modulo 10**DIGITS, digit0 in [3:0]
//   ovf                  : operand was >= 10**DIGITS
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned TOT_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  // 10**DIGITS < 2**BCD_W, so this width holds both the limit and any operand.
  localparam int unsigned CMP_W = ((BIN_W > BCD_W) ? BIN_W : BCD_W) + 1;

  function automatic logic [CMP_W-1:0] pow10(input int unsigned n);
    logic [CMP_W-1:0] r;
    r = CMP_W'(1);
    for (int unsigned i = 0; i < n; i++) r = CMP_W'(r * CMP_W'(10));
    return r;
  endfunction

  localparam logic [CMP_W-1:0] BCD_LIMIT = pow10(DIGITS);

  cvt_state_e         state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   accum_q, accum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [BCD_W-1:0]   accum_fix;
  logic [TOT_W-1:0]   shifted;

  // Per-digit correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .digit_in    (accum_q[4*g +: 4]),
      .digit_out_c (accum_fix[4*g +: 4])
    );
  end

  // Top accumulator bit falls off, leaving the result modulo 10**DIGITS.
  assign shifted = {accum_fix, shift_q} << 1;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    accum_d     = accum_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          shift_d    = bin_in;
          accum_d    = '0;
          ovf_d      = (CMP_W'(bin_in) >= BCD_LIMIT);
          cnt_d      = CNT_W'(BIN_W);
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        accum_d = shifted[TOT_W-1:BIN_W];
        shift_d = shifted[BIN_W-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // All converter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      accum_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      accum_q     <= accum_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = accum_q;
  assign ovf       = ovf_q;

  // Accumulator digits must stay decimal throughout the shift phase.
  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    always @(posedge clk) begin
      if (!rst && state_q == SHIFT) begin
        assert (accum_q[4*g +: 4] <= 4'd9)
          else $error("bcd digit %0d out of range", g);
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=2) against a
// plain-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bin_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] bcd_out;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: value modulo 100 as two decimal digits, overflow at >= 100.
  function automatic logic [7:0] ref_bcd(input int v);
    int m;
    m = v % 100;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic ref_ovf(input int v);
    return v >= 100;
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Ongoing invariants: decimal digits and no simultaneous in_ready/out_valid.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (bcd_out[3:0] > 4'd9 || bcd_out[7:4] > 4'd9) begin
        n_fail++;
        $display("FAIL digit_range: bcd_out=%h required digits<=9", bcd_out);
      end
      n_checks++;
      if (in_ready && out_valid) begin
        n_fail++;
        $display("FAIL ready_valid_overlap: in_ready=%b out_valid=%b required not both 1", in_ready, out_valid);
      end
    end
  end

  // Stimulus only: capture v, wait for the result, optionally accept it.
  task automatic convert(input int v, input bit accept,
                         output logic [7:0] r, output logic o, output int lat);
    lat = -1;
    r   = 'x;
    o   = 1'bx;
    for (int i = 0; i < 30 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    bin_in   = 8'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) return;
    r = bcd_out;
    o = ovf;
    if (accept) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] r; logic o; int lat;
    rst = 1'b1;
    #2;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
    end
    convert(55, 1'b1, r, o, lat);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || bcd_out !== 8'h00 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: out_valid=%b bcd_out=%h ovf=%b in_ready=%b want 0 00 0 0",
               out_valid, bcd_out, ovf, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] r; logic o; int lat;
    convert(9, 1'b1, r, o, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 8", lat);
    end
    n_checks++;
    if (r !== 8'h09 || o !== 1'b0) begin
      n_fail++; $display("FAIL basic_9: bcd=%h ovf=%b want 09 0", r, o);
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd_out !== 8'h09) begin
      n_fail++;
      $display("FAIL basic_after_accept: out_valid=%b in_ready=%b bcd_out=%h want 0 1 09",
               out_valid, in_ready, bcd_out);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] r, a41, b11; logic o; int lat;
    int vals [4] = '{0, 10, 41, 99};
    foreach (vals[k]) begin
      convert(vals[k], 1'b1, r, o, lat);
      n_checks++;
      if (r !== ref_bcd(vals[k]) || o !== 1'b0 || lat !== 8) begin
        n_fail++;
        $display("FAIL sweep_%0d: bcd=%h ovf=%b lat=%0d want %h 0 8",
                 vals[k], r, o, lat, ref_bcd(vals[k]));
      end
      if (vals[k] == 41) a41 = r;
    end
    convert(11, 1'b1, b11, o, lat);
    n_checks++;
    if ((bcd_val(a41) + bcd_val(b11)) % 100 !== bcd_val(8'h52) ||
        (bcd_val(a41) + bcd_val(b11)) >= 100) begin
      n_fail++;
      $display("FAIL adder_41_11: operands %h+%h want sum 52 carry 0", a41, b11);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] r; logic o; int lat;
    convert(100, 1'b1, r, o, lat);
    n_checks++;
    if (r !== 8'h00 || o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_100: bcd=%h ovf=%b want 00 1", r, o);
    end
    convert(255, 1'b1, r, o, lat);
    n_checks++;
    if (r !== 8'h55 || o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_255: bcd=%h ovf=%b want 55 1", r, o);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r; logic o; int lat; int bad;
    convert(123, 1'b0, r, o, lat);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      bin_in   = 8'(c * 37 + 3);
      @(posedge clk); #1;
      if (bcd_out !== 8'h23 || ovf !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (lat !== 8 || bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: lat=%0d unstable_cycles=%0d want 8 0", lat, bad);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bin_in    = 8'd7;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd_out !== 8'h23) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b bcd_out=%h want 0 1 23",
               out_valid, in_ready, bcd_out);
    end
  endtask

  task automatic test_rst_mid_shift();
    logic [7:0] r; logic o; int lat; int seen;
    for (int i = 0; i < 30 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    bin_in   = 8'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || bcd_out !== 8'h00 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_shift_now: out_valid=%b bcd_out=%h in_ready=%b want 0 00 0",
               out_valid, bcd_out, in_ready);
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL rst_shift_discard: out_valid cycles=%0d want 0", seen);
    end
    convert(42, 1'b1, r, o, lat);
    n_checks++;
    if (r !== 8'h42 || o !== 1'b0 || lat !== 8) begin
      n_fail++; $display("FAIL rst_shift_42: bcd=%h ovf=%b lat=%0d want 42 0 8", r, o, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] r; logic o; int lat; int v; int dly;
    for (int k = 0; k < 40; k++) begin
      v   = int'($urandom_range(255, 0));
      dly = int'($urandom_range(3, 0));
      convert(v, 1'b0, r, o, lat);
      repeat (dly) begin
        @(posedge clk); #1;
      end
      n_checks++;
      if (r !== ref_bcd(v) || o !== ref_ovf(v) || lat !== 8 || bcd_out !== ref_bcd(v)) begin
        n_fail++;
        $display("FAIL random_%0d: bcd=%h held=%h ovf=%b lat=%0d want %h %h %b 8",
                 v, r, bcd_out, o, lat, ref_bcd(v), ref_bcd(v), ref_ovf(v));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int caps [$];
    int t;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bin_in    = 8'd63;
    t = 0;
    while (caps.size() < 3 && t < 100) begin
      if (in_valid && in_ready) caps.push_back(t);
      @(posedge clk); #1;
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (caps.size() !== 3) begin
      n_fail++; $display("FAIL b2b_captures: got %0d want 3", caps.size());
    end else if (caps[1] - caps[0] !== 10 || caps[2] - caps[1] !== 10) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d,%0d want 10,10", caps[1] - caps[0], caps[2] - caps[1]);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = 8'h00;
    test_reset();
    test_basic();
    test_sweep();
    test_overflow();
    test_backpressure();
    test_rst_mid_shift();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
